// File: rtl/game_pkg.sv
// Shared types and codes for the dice game round sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    P1_ROLL,
    P2_ROLL,
    RESULT
  } state_t;

  localparam logic [1:0] COLOR_OFF   = 2'b00;
  localparam logic [1:0] COLOR_RED   = 2'b01;
  localparam logic [1:0] COLOR_GREEN = 2'b10;
  localparam logic [1:0] COLOR_BLUE  = 2'b11;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_LEFT  = 2'b01;
  localparam logic [1:0] LED_RIGHT = 2'b10;

  localparam int unsigned DICE_MAX = 5;
  localparam logic [2:0]  WINS_MAX = 3'd7;

endpackage

// File: rtl/roll_counter.sv
// Free-running 1..DICE_MAX wrapping counter sampled as the die value.
module roll_counter
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] value
);

  logic [2:0] value_q;
  logic [2:0] value_d;

  always_comb begin
    value_d = value_q + 3'd1;
    if (value_q >= 3'(DICE_MAX)) begin
      value_d = 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q <= 3'd1;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/dice_turn_controller.sv
// Two-player dice round sequencer: start, two rolls, result hold, back to idle.
// Optional per-turn forfeit timer compiled in with TURN_TIMEOUT_EN.
module dice_turn_controller
  import game_pkg::*;
#(
  parameter int unsigned RESULT_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  output logic [2:0] dice1,
  output logic [2:0] dice2,
  output logic [1:0] c_value1,
  output logic [1:0] c_value2,
  output logic [1:0] LED_sig,
  output logic [2:0] wins1,
  output logic [2:0] wins2
);

  // One phase timer serves both the result hold and the turn timeout; they never overlap.
  localparam int unsigned TimerMax =
      (RESULT_CYCLES > TIMEOUT_CYCLES) ? RESULT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = $clog2(TimerMax + 1);

  state_t            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        dice1_q, dice1_d;
  logic [2:0]        dice2_q, dice2_d;
  logic [1:0]        c1_q, c1_d;
  logic [1:0]        c2_q, c2_d;
  logic [1:0]        led_q, led_d;
  logic [2:0]        wins1_q, wins1_d;
  logic [2:0]        wins2_q, wins2_d;

  logic [2:0] roll;
  logic [2:0] p2_value;
  logic       turn_expired;
  logic       turn_tick;

  roll_counter u_roll_counter (
    .clk   (clk),
    .rst   (rst),
    .value (roll)
  );

`ifdef TURN_TIMEOUT_EN
  assign turn_expired = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
  assign turn_tick    = 1'b1;
`else
  assign turn_expired = 1'b0;
  assign turn_tick    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dice1_d  = dice1_q;
    dice2_d  = dice2_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    led_d    = led_q;
    wins1_d  = wins1_q;
    wins2_d  = wins2_q;
    // A forfeited turn scores 0, which loses to any rolled value.
    p2_value = btn2 ? roll : 3'd0;

    unique case (state_q)
      IDLE: begin
        if (btn1 || btn2) begin
          state_d = P1_ROLL;
          timer_d = '0;
          dice1_d = 3'd0;
          dice2_d = 3'd0;
          c1_d    = COLOR_OFF;
          c2_d    = COLOR_OFF;
          led_d   = LED_LEFT;
        end
      end
      P1_ROLL: begin
        if (turn_tick) begin
          timer_d = timer_q + TimerW'(1);
        end
        if (btn1 || turn_expired) begin
          state_d = P2_ROLL;
          timer_d = '0;
          led_d   = LED_RIGHT;
          if (btn1) begin
            dice1_d = roll;
          end
        end
      end
      P2_ROLL: begin
        if (turn_tick) begin
          timer_d = timer_q + TimerW'(1);
        end
        if (btn2 || turn_expired) begin
          state_d = RESULT;
          timer_d = '0;
          dice2_d = p2_value;
          if (dice1_q > p2_value) begin
            c1_d    = COLOR_GREEN;
            c2_d    = COLOR_RED;
            led_d   = LED_LEFT;
            wins1_d = (wins1_q == WINS_MAX) ? wins1_q : wins1_q + 3'd1;
          end else if (p2_value > dice1_q) begin
            c1_d    = COLOR_RED;
            c2_d    = COLOR_GREEN;
            led_d   = LED_RIGHT;
            wins2_d = (wins2_q == WINS_MAX) ? wins2_q : wins2_q + 3'd1;
          end else begin
            c1_d  = COLOR_BLUE;
            c2_d  = COLOR_BLUE;
            led_d = LED_OFF;
          end
        end
      end
      RESULT: begin
        if (timer_q == TimerW'(RESULT_CYCLES - 1)) begin
          state_d = IDLE;
          led_d   = LED_OFF;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      dice1_q <= 3'd0;
      dice2_q <= 3'd0;
      c1_q    <= COLOR_OFF;
      c2_q    <= COLOR_OFF;
      led_q   <= LED_OFF;
      wins1_q <= 3'd0;
      wins2_q <= 3'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dice1_q <= dice1_d;
      dice2_q <= dice2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      led_q   <= led_d;
      wins1_q <= wins1_d;
      wins2_q <= wins2_d;
    end
  end

  assign dice1    = dice1_q;
  assign dice2    = dice2_q;
  assign c_value1 = c1_q;
  assign c_value2 = c2_q;
  assign LED_sig  = led_q;
  assign wins1    = wins1_q;
  assign wins2    = wins2_q;

endmodule

// File: tb/tb_dice_turn_controller.sv
// Randomised bench for dice_turn_controller against a round-level reference model.
module tb_dice_turn_controller;

  localparam int unsigned RC = 8;
  localparam int unsigned TC = 16;
`ifdef TURN_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       btn1 = 1'b0;
  logic       btn2 = 1'b0;
  logic [2:0] dice1, dice2, wins1, wins2;
  logic [1:0] c_value1, c_value2, LED_sig;

  dice_turn_controller #(
    .RESULT_CYCLES  (RC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn1     (btn1),
    .btn2     (btn2),
    .dice1    (dice1),
    .dice2    (dice2),
    .c_value1 (c_value1),
    .c_value2 (c_value2),
    .LED_sig  (LED_sig),
    .wins1    (wins1),
    .wins2    (wins2)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 player-1 turn, 2 player-2 turn, 3 result.
  // Die value is derived from the cycle count since reset.
  bit m_valid = 1'b0;
  int m_age   = 0;
  int m_phase = 0;
  int m_since = 0;
  int m_d1 = 0, m_d2 = 0, m_c1 = 0, m_c2 = 0, m_led = 0, m_w1 = 0, m_w2 = 0;

  function automatic int next_roll();
    return (m_age % 5) + 1;
  endfunction

  always @(posedge clk) begin
    int  roll;
    bit  expired;
    roll    = next_roll();
    expired = TimeoutOn && (m_since == TC - 1);
    if (!rst) begin
      m_valid = 1'b1;
      m_age = 0; m_phase = 0; m_since = 0;
      m_d1 = 0; m_d2 = 0; m_c1 = 0; m_c2 = 0; m_led = 0; m_w1 = 0; m_w2 = 0;
    end else begin
      m_age++;
      case (m_phase)
        0: if (btn1 || btn2) begin
          m_phase = 1; m_since = 0;
          m_d1 = 0; m_d2 = 0; m_c1 = 0; m_c2 = 0; m_led = 1;
        end
        1: if (btn1 || expired) begin
          m_d1 = btn1 ? roll : 0;
          m_phase = 2; m_since = 0; m_led = 2;
        end else m_since++;
        2: if (btn2 || expired) begin
          m_d2 = btn2 ? roll : 0;
          m_phase = 3; m_since = 0;
          if (m_d1 > m_d2) begin
            m_c1 = 2; m_c2 = 1; m_led = 1; if (m_w1 < 7) m_w1++;
          end else if (m_d2 > m_d1) begin
            m_c1 = 1; m_c2 = 2; m_led = 2; if (m_w2 < 7) m_w2++;
          end else begin
            m_c1 = 3; m_c2 = 3; m_led = 0;
          end
        end else m_since++;
        default: if (m_since == RC - 1) begin
          m_phase = 0; m_led = 0;
        end else m_since++;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model dice1", int'(dice1), m_d1);
      chk("model dice2", int'(dice2), m_d2);
      chk("model c_value1", int'(c_value1), m_c1);
      chk("model c_value2", int'(c_value2), m_c2);
      chk("model LED_sig", int'(LED_sig), m_led);
      chk("model wins1", int'(wins1), m_w1);
      chk("model wins2", int'(wins2), m_w2);
    end
  end

  // Called at a negedge; the pulse is sampled by the next posedge.
  task automatic press(input bit b1, input bit b2);
    btn1 = b1;
    btn2 = b2;
    @(negedge clk);
    btn1 = 1'b0;
    btn2 = 1'b0;
  endtask

  task automatic press_at(input bit b1, input bit b2, input int v);
    while (next_roll() != v) @(negedge clk);
    press(b1, b2);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset dice1", int'(dice1), 0);
    chk("reset dice2", int'(dice2), 0);
    chk("reset c_value1", int'(c_value1), 0);
    chk("reset c_value2", int'(c_value2), 0);
    chk("reset LED_sig", int'(LED_sig), 0);
    chk("reset wins1", int'(wins1), 0);
    chk("reset wins2", int'(wins2), 0);
    rst = 1'b1;

    // Player 1 wins 4 vs 2.
    press(1'b1, 1'b0);
    chk("start LED_sig", int'(LED_sig), 1);
    press_at(1'b1, 1'b0, 4);
    chk("p1 dice1", int'(dice1), 4);
    chk("p1 LED_sig", int'(LED_sig), 2);
    press_at(1'b0, 1'b1, 2);
    chk("win dice2", int'(dice2), 2);
    chk("win c_value1", int'(c_value1), 2);
    chk("win c_value2", int'(c_value2), 1);
    chk("win LED_sig", int'(LED_sig), 1);
    chk("win wins1", int'(wins1), 1);
    repeat (RC - 1) @(negedge clk);
    chk("result hold LED_sig", int'(LED_sig), 1);
    @(negedge clk);
    chk("idle LED_sig", int'(LED_sig), 0);
    chk("idle keeps dice1", int'(dice1), 4);

    // Tie at 3, started by player 2's button.
    press(1'b0, 1'b1);
    press_at(1'b1, 1'b0, 3);
    press_at(1'b0, 1'b1, 3);
    chk("tie c_value1", int'(c_value1), 3);
    chk("tie c_value2", int'(c_value2), 3);
    chk("tie LED_sig", int'(LED_sig), 0);
    chk("tie wins1", int'(wins1), 1);
    chk("tie wins2", int'(wins2), 0);
    repeat (RC) @(negedge clk);

    // Wrong-player presses ignored; simultaneous presses count for the active player.
    press(1'b1, 1'b1);
    press(1'b0, 1'b1);
    chk("p1 ignores btn2 LED", int'(LED_sig), 1);
    chk("p1 ignores btn2 dice1", int'(dice1), 0);
    press_at(1'b1, 1'b1, 5);
    chk("both in p1 dice1", int'(dice1), 5);
    chk("both in p1 LED", int'(LED_sig), 2);
    press(1'b1, 1'b0);
    chk("p2 ignores btn1", int'(dice2), 0);
    press_at(1'b1, 1'b1, 5);
    chk("both in p2 c_value2", int'(c_value2), 3);
    repeat (RC) @(negedge clk);

    // Saturation of player-1 wins.
    repeat (8) begin
      press(1'b1, 1'b0);
      press_at(1'b1, 1'b0, 5);
      press_at(1'b0, 1'b1, 1);
      repeat (RC) @(negedge clk);
    end
    chk("saturated wins1", int'(wins1), 7);
    chk("saturated wins2", int'(wins2), 0);

    // Reset in the middle of player 2's turn.
    press(1'b1, 1'b0);
    press_at(1'b1, 1'b0, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset wins1", int'(wins1), 0);
    chk("mid reset LED", int'(LED_sig), 0);
    chk("mid reset dice1", int'(dice1), 0);
    rst = 1'b1;

    // Idle player 1 turn.
    press(1'b1, 1'b0);
`ifdef TURN_TIMEOUT_EN
    repeat (TC - 1) @(negedge clk);
    chk("before timeout LED", int'(LED_sig), 1);
    @(negedge clk);
    chk("timeout LED", int'(LED_sig), 2);
    chk("timeout dice1", int'(dice1), 0);
    press_at(1'b0, 1'b1, 1);
    chk("forfeit c_value1", int'(c_value1), 1);
    chk("forfeit c_value2", int'(c_value2), 2);
    chk("forfeit wins2", int'(wins2), 1);
    repeat (RC) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    chk("no timeout LED", int'(LED_sig), 1);
    chk("no timeout dice1", int'(dice1), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      btn1 = ($urandom_range(0, 3) == 0);
      btn2 = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    btn1 = 1'b0;
    btn2 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
